// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory and control-side signals of the fetch unit.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] next_pc;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
    logic        fetch_err;
    modport master (
        output imem_req, imem_addr, inst, pc, inst_valid, fetch_err,
        input  imem_ack, imem_rdata, next_pc, stall
    );
    modport slave (
        input  imem_req, imem_addr, inst, pc, inst_valid, fetch_err,
        output imem_ack, imem_rdata, next_pc, stall
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: REQ/EXEC/ERR instruction fetch FSM with sticky fault flag.
// Define IFETCH_TIMEOUT_EN to fault after TIMEOUT_CYCLES unacknowledged REQ cycles.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);
    typedef enum logic [1:0] {REQ, EXEC, ERR} state_t;
    state_t      state, state_nx;
    logic [31:0] pc_q, pc_nx, inst_q, inst_nx;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] cnt, cnt_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= REQ;
            pc_q   <= RESET_PC;
            inst_q <= 32'h0000_0000;
`ifdef IFETCH_TIMEOUT_EN
            cnt    <= 8'd0;
`endif
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            inst_q <= inst_nx;
`ifdef IFETCH_TIMEOUT_EN
            cnt    <= cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        inst_nx  = inst_q;
`ifdef IFETCH_TIMEOUT_EN
        cnt_nx   = 8'd0;
`endif
        case (state)
            REQ: begin
                if (bus.imem_ack) begin
                    inst_nx  = bus.imem_rdata;
                    state_nx = EXEC;
                end
`ifdef IFETCH_TIMEOUT_EN
                else begin
                    cnt_nx   = cnt + 8'd1;
                    state_nx = (cnt_nx == 8'(TIMEOUT_CYCLES)) ? ERR : REQ;
                end
`endif
            end
            EXEC: begin
                if (!bus.stall) begin
                    // a misaligned target faults without disturbing pc
                    pc_nx    = (bus.next_pc[1:0] == 2'b00) ? bus.next_pc : pc_q;
                    state_nx = (bus.next_pc[1:0] == 2'b00) ? REQ : ERR;
                end
            end
            default: ;
        endcase
    end

    // the async reset already forces REQ, so the request is gated by rst_n directly
    assign bus.imem_req   = rst_n && (state == REQ);
    assign bus.inst_valid = rst_n && (state == EXEC);
    assign bus.fetch_err  = (state == ERR);
    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.inst       = inst_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed stimulus with a per-cycle reference model comparison.
module tb_ifetch_unit;
    localparam int TMO = 16;
`ifdef IFETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    ifetch_unit_if bus();
    ifetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    // reference model: "holding an instruction", "dead", count of missed requests
    logic [31:0] m_pc, m_inst;
    logic        m_exec, m_err;
    int          m_miss;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_inst <= 32'h0; m_exec <= 1'b0; m_err <= 1'b0; m_miss <= 0;
        end else if (!m_err) begin
            if (!m_exec) begin
                if (bus.imem_ack) begin
                    m_inst <= bus.imem_rdata; m_exec <= 1'b1; m_miss <= 0;
                end else begin
                    m_miss <= m_miss + 1;
                    if (TMO_EN && m_miss + 1 >= TMO) m_err <= 1'b1;
                end
            end else if (!bus.stall) begin
                if (bus.next_pc % 4 == 0) begin
                    m_pc <= bus.next_pc; m_exec <= 1'b0;
                end else m_err <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_req",   32'(bus.imem_req),   32'(!m_exec && !m_err));
            chk("m_valid", 32'(bus.inst_valid), 32'(m_exec && !m_err));
            chk("m_err",   32'(bus.fetch_err),  32'(m_err));
            chk("m_addr",  bus.imem_addr, m_pc);
            chk("m_pc",    bus.pc, m_pc);
            chk("m_inst",  bus.inst, m_inst);
        end else begin
            chk("m_rst_req",   32'(bus.imem_req), 32'h0);
            chk("m_rst_valid", 32'(bus.inst_valid), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq_pc [6] = '{32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC};
    logic        seq_v  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2008_0005;
        bus.next_pc = 32'h0; bus.stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_err", 32'(bus.fetch_err), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("c1_req", 32'(bus.imem_req), 32'h1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        chk("c1_valid", 32'(bus.inst_valid), 32'h0);
        step();
        chk("c2_inst", bus.inst, 32'h2008_0005);
        chk("c2_valid", 32'(bus.inst_valid), 32'h1);
        chk("model_inst", m_inst, 32'h2008_0005);
        bus.stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.next_pc = seq_pc[i];
            bus.imem_rdata = 32'h1000_0000 + 32'(i);
            step();
            chk("seq_pc", bus.pc, seq_pc[i]);
            chk("seq_valid", 32'(bus.inst_valid), 32'(seq_v[i]));
        end
        bus.stall = 1'b1; bus.next_pc = 32'h10;
        repeat (3) begin
            step();
            chk("stall_pc", bus.pc, 32'hC);
            chk("stall_inst", bus.inst, 32'h1000_0005);
            chk("stall_req", 32'(bus.imem_req), 32'h0);
        end
        bus.stall = 1'b0;
        step();
        chk("post_stall_addr", bus.imem_addr, 32'h10);
        chk("post_stall_req", 32'(bus.imem_req), 32'h1);
        step();
        bus.next_pc = 32'hFFFF_FFFC;
        step();
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        bus.next_pc = 32'h0;
        step();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        step();
        bus.next_pc = 32'h20;
        step();
        step();
        chk("pre_rst_pc", bus.pc, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", 32'(bus.imem_req), 32'h0);
        chk("async_valid", 32'(bus.inst_valid), 32'h0);
        chk("async_pc", bus.pc, 32'h0);
        chk("async_inst", bus.inst, 32'h0);
        bus.imem_rdata = 32'hDEAD_BEEC;
        step();
        chk("rst_ack_discard", bus.inst, 32'h0);
        rst_n = 1'b1; bus.imem_rdata = 32'h0000_0013; bus.next_pc = 32'h8;
        step();
        chk("refetch_inst", bus.inst, 32'h0000_0013);
        step();
        step();
        chk("pre_mis_pc", bus.pc, 32'h8);
        bus.next_pc = 32'h6; bus.imem_rdata = 32'hFFFF_0000;
        step();
        chk("mis_err", 32'(bus.fetch_err), 32'h1);
        chk("mis_pc", bus.pc, 32'h8);
        chk("mis_valid", 32'(bus.inst_valid), 32'h0);
        chk("model_err", 32'(m_err), 32'h1);
        repeat (5) step();
        chk("err_sticky", 32'(bus.fetch_err), 32'h1);
        chk("err_req", 32'(bus.imem_req), 32'h0);
        chk("err_inst", bus.inst, 32'h0000_0013);
        rst_n = 1'b0; bus.imem_ack = 1'b0;
        step();
        rst_n = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
        repeat (TMO - 1) step();
        chk("tmo_before", 32'(bus.fetch_err), 32'h0);
        chk("tmo_req", 32'(bus.imem_req), 32'h1);
        step();
        chk("tmo_err", 32'(bus.fetch_err), 32'h1);
`else
        repeat (100) step();
        chk("no_tmo_err", 32'(bus.fetch_err), 32'h0);
        chk("no_tmo_req", 32'(bus.imem_req), 32'h1);
        chk("no_tmo_addr", bus.imem_addr, 32'h0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
